// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects operand A, operand B and the opcode from a shared
// switch bank, one value per press of the load button. All outputs are registered.
// The clear button returns the loader to the first operand.
// Optional feature macro: DEBOUNCE_EN. When it is defined, each synchronized button
// must hold a new level for DEB_CYCLES cycles before the change is accepted.
module alu_operand_loader #(
  parameter int WIDTH      = 4,
  parameter int OPW        = 2,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btnLoad,
  input  logic             btnClear,
  output logic [WIDTH-1:0] inputA,
  output logic [WIDTH-1:0] inputB,
  output logic [OPW-1:0]   opcode,
  output logic [1:0]       state,
  output logic             valid,
  output logic             divZero
);

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_OP    = 2'b10,
    S_READY = 2'b11
  } state_t;

  state_t state_q;

  // Bit 0 carries the load button and bit 1 carries the clear button.
  logic [1:0] btn_raw;
  logic [1:0] btn_sync_p0;
  logic [1:0] btn_sync_p1;
  logic [1:0] btn_filt;
  logic [1:0] btn_prev;
  logic       load_pulse;
  logic       clear_lvl;

  assign btn_raw = {btnClear, btnLoad};

  // A divide-by-zero request needs a complete operand set, a divide-class opcode
  // (opcode bit 1) and a zero divisor.
  function automatic logic div_zero_chk(input logic             vld,
                                        input logic [OPW-1:0]   op,
                                        input logic [WIDTH-1:0] b);
    return vld & op[1] & (b == '0);
  endfunction

  // ---- stage p0/p1: two-flop synchronizer for both asynchronous buttons ----
  // Two-flop synchronizer for both asynchronous buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
    end
  end

  // ---- filter stage: optional debounce of the synchronized levels ----
`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0][CNT_W-1:0] deb_cnt;

  // Accept a new level only after DEB_CYCLES consecutive samples of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt  <= '0;
      btn_filt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync_p1[i] != btn_filt[i]) begin
          if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
            btn_filt[i] <= btn_sync_p1[i];
            deb_cnt[i]  <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign btn_filt = btn_sync_p1;
`endif

  // ---- edge stage: rising-edge detect on the filtered load level ----
  // Remember the previous filtered levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_prev <= '0;
    end else begin
      btn_prev <= btn_filt;
    end
  end

  assign load_pulse = btn_filt[0] & ~btn_prev[0];
  assign clear_lvl  = btn_filt[1];

  // ---- capture stage: operand FSM and registered outputs ----
  // Operand FSM. Clear overrides load. divZero is computed from the values being loaded.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_lvl) begin
      state_q <= S_A;
      inputA  <= '0;
      inputB  <= '0;
      opcode  <= '0;
      valid   <= 1'b0;
      divZero <= 1'b0;
    end else if (load_pulse) begin
      case (state_q)
        S_A: begin
          inputA  <= sw;
          valid   <= 1'b0;
          divZero <= 1'b0;
          state_q <= S_B;
        end
        S_B: begin
          inputB  <= sw;
          valid   <= 1'b0;
          divZero <= 1'b0;
          state_q <= S_OP;
        end
        S_OP: begin
          opcode  <= sw[OPW-1:0];
          valid   <= 1'b1;
          divZero <= div_zero_chk(1'b1, sw[OPW-1:0], inputB);
          state_q <= S_READY;
        end
        default: begin
          // A press after a complete set starts a new sequence with operand A.
          inputA  <= sw;
          valid   <= 1'b0;
          divZero <= 1'b0;
          state_q <= S_B;
        end
      endcase
    end else begin
      divZero <= div_zero_chk(valid, opcode, inputB);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Testbench for alu_operand_loader: a vector table of presses plus hand-written
// sequences for reset, latency, glitches, clear priority and mid-sequence reset.
module tb_alu_operand_loader;

  localparam int WIDTH = 4;
  localparam int OPW   = 2;
`ifdef DEBOUNCE_EN
  localparam int PRESS      = 25;
  localparam int LAT        = 19;
  localparam int GLITCH_EXP = 0;
`else
  localparam int PRESS      = 4;
  localparam int LAT        = 3;
  localparam int GLITCH_EXP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sw;
  logic             btnLoad;
  logic             btnClear;
  logic [WIDTH-1:0] inputA;
  logic [WIDTH-1:0] inputB;
  logic [OPW-1:0]   opcode;
  logic [1:0]       state;
  logic             valid;
  logic             divZero;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(.WIDTH(WIDTH), .OPW(OPW), .DEB_CYCLES(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .btnLoad (btnLoad),
    .btnClear(btnClear),
    .inputA  (inputA),
    .inputB  (inputB),
    .opcode  (opcode),
    .state   (state),
    .valid   (valid),
    .divZero (divZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [1:0] st;
    logic       v;
    logic       dz;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int a, input int b, input int op,
                         input int st, input int v, input int dz);
    chk({tag, ".inputA"},  int'(inputA),  a);
    chk({tag, ".inputB"},  int'(inputB),  b);
    chk({tag, ".opcode"},  int'(opcode),  op);
    chk({tag, ".state"},   int'(state),   st);
    chk({tag, ".valid"},   int'(valid),   v);
    chk({tag, ".divZero"}, int'(divZero), dz);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw      = v;
    btnLoad = 1'b1;
    repeat (PRESS) @(negedge clk);
    btnLoad = 1'b0;
    repeat (PRESS) @(negedge clk);
  endtask

  // divZero must never be set without a valid operand set.
  always @(negedge clk) begin
    if (rst_n && !valid && divZero) begin
      errors++;
      $display("FAIL divZero_without_valid: got divZero=1, expected 0");
    end
  end

  initial begin
    int lat;

    //           sw     A      B      op     st     v     dz
    vecs[0]  = '{4'h9, 4'h9, 4'h0, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[1]  = '{4'h2, 4'h9, 4'h2, 2'b00, 2'b10, 1'b0, 1'b0};
    vecs[2]  = '{4'h2, 4'h9, 4'h2, 2'b10, 2'b11, 1'b1, 1'b0};
    vecs[3]  = '{4'h7, 4'h7, 4'h2, 2'b10, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{4'h0, 4'h7, 4'h0, 2'b10, 2'b10, 1'b0, 1'b0};
    vecs[5]  = '{4'h3, 4'h7, 4'h0, 2'b11, 2'b11, 1'b1, 1'b1};
    vecs[6]  = '{4'h5, 4'h5, 4'h0, 2'b11, 2'b01, 1'b0, 1'b0};
    vecs[7]  = '{4'h0, 4'h5, 4'h0, 2'b11, 2'b10, 1'b0, 1'b0};
    vecs[8]  = '{4'hD, 4'h5, 4'h0, 2'b01, 2'b11, 1'b1, 1'b0};
    vecs[9]  = '{4'h6, 4'h6, 4'h0, 2'b01, 2'b01, 1'b0, 1'b0};
    vecs[10] = '{4'hF, 4'h6, 4'hF, 2'b01, 2'b10, 1'b0, 1'b0};
    vecs[11] = '{4'hE, 4'h6, 4'hF, 2'b10, 2'b11, 1'b1, 1'b0};

    rst_n    = 1'b0;
    sw       = 4'hA;
    btnLoad  = 1'b0;
    btnClear = 1'b0;

    // Reset clears everything; an idle button changes nothing.
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_all("idle", 0, 0, 0, 0, 0, 0);

    // Latency from a raw rise to the capture, with a long hold giving one capture.
    sw      = 4'h3;
    btnLoad = 1'b1;
    lat     = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && state != 2'b00) lat = k;
    end
    @(negedge clk);
    btnLoad = 1'b0;
    chk("latency", lat, LAT);
    chk("long_press.state", int'(state), 1);
    chk("long_press.inputA", int'(inputA), 3);
    repeat (PRESS) @(negedge clk);

    // A five-cycle glitch.
    do_reset();
    sw      = 4'h8;
    btnLoad = 1'b1;
    repeat (5) @(negedge clk);
    btnLoad = 1'b0;
    repeat (PRESS + 5) @(negedge clk);
    chk("glitch.state", int'(state), GLITCH_EXP);

    // A button held through reset release gives exactly one capture.
    sw      = 4'hC;
    btnLoad = 1'b1;
    do_reset();
    repeat (PRESS + 10) @(negedge clk);
    chk("held_reset.state", int'(state), 1);
    chk("held_reset.inputA", int'(inputA), 12);
    btnLoad = 1'b0;
    repeat (PRESS) @(negedge clk);

    // Table of presses from a clean start.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      press(vecs[i].sw);
      chk_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].st, vecs[i].v, vecs[i].dz);
    end

    // Clear and load together in S_OP: clear wins and sw is not captured.
    do_reset();
    press(4'h3);
    press(4'h4);
    chk("pre_clear.state", int'(state), 2);
    @(negedge clk);
    sw       = 4'h2;
    btnLoad  = 1'b1;
    btnClear = 1'b1;
    repeat (PRESS) @(negedge clk);
    btnLoad  = 1'b0;
    btnClear = 1'b0;
    repeat (PRESS) @(negedge clk);
    chk_all("clear_wins", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a sequence abandons the partial operands.
    press(4'h6);
    chk("pre_reset.state", int'(state), 1);
    chk("pre_reset.inputA", int'(inputA), 6);
    do_reset();
    chk_all("reset_in_SB", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
